// File: rtl/cpu_boot_ctrl.sv
// Boot/run controller: streams a loader image into the Cpu RAM while the Cpu is held in reset,
// holds reset for RESET_HOLD cycles, then supervises the run until halt or cycle-limit timeout.
module cpu_boot_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int RESET_HOLD = 10,
    parameter int RUN_LIMIT  = 100,
    parameter int CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              load_last_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              cpu_rst_o,
    input  logic              cpu_halt_i,
    output logic [2:0]        state_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              overflow_o,
    output logic [ADDR_W:0]   words_loaded_o,
    output logic [CNT_W-1:0]  cycle_count_o
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   WL_ONE    = (ADDR_W+1)'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  LIMIT_END = CNT_W'(RUN_LIMIT - 1);

    logic [2:0]        state_q, state_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic handshake;
    logic ptr_at_end;
    logic hold_end;
    logic limit_hit;

    assign handshake  = load_valid_i && (state_q == S_LOAD);
    assign ptr_at_end = (ptr_q == PTR_LAST);
    assign hold_end   = (hold_cnt_q == HOLD_END);
    assign limit_hit  = (RUN_LIMIT != 0) && (cycle_count_q == LIMIT_END);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_LOAD;
            S_LOAD: if (handshake && (load_last_i || ptr_at_end)) state_d = S_HOLD;
            S_HOLD: if (hold_end) state_d = S_RUN;
            S_RUN:  if (cpu_halt_i || limit_hit) state_d = S_DONE;
            S_DONE: if (start_i) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values; every output is registered from these
    always_comb begin
        cpu_rst_d      = (state_d != S_RUN);
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        done_d         = done_q;
        timeout_d      = timeout_q;
        overflow_d     = overflow_q;
        words_loaded_d = words_loaded_q;
        cycle_count_d  = cycle_count_q;
        ptr_d          = ptr_q;
        hold_cnt_d     = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_IDLE || start_i) begin
                    done_d         = 1'b0;
                    timeout_d      = 1'b0;
                    overflow_d     = 1'b0;
                    words_loaded_d = '0;
                    cycle_count_d  = '0;
                    ptr_d          = '0;
                end
            end
            S_LOAD: begin
                if (handshake) begin
                    mem_we_d       = 1'b1;
                    mem_addr_d     = ptr_q;
                    mem_wdata_d    = load_data_i;
                    words_loaded_d = words_loaded_q + WL_ONE;
                    // The pointer parks on the last address instead of wrapping
                    if (!ptr_at_end) ptr_d = ptr_q + PTR_ONE;
                    if (ptr_at_end && !load_last_i) overflow_d = 1'b1;
                end
            end
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
            S_RUN: begin
                if (cycle_count_q != CNT_MAX) cycle_count_d = cycle_count_q + CNT_ONE;
                if (cpu_halt_i) begin
                    done_d = 1'b1;
                end else if (limit_hit) begin
                    timeout_d = 1'b1;
                end
            end
            default: begin
                cpu_rst_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_rst_q      <= 1'b1;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            overflow_q     <= 1'b0;
            words_loaded_q <= '0;
            cycle_count_q  <= '0;
            ptr_q          <= '0;
            hold_cnt_q     <= '0;
        end else begin
            cpu_rst_q      <= cpu_rst_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            done_q         <= done_d;
            timeout_q      <= timeout_d;
            overflow_q     <= overflow_d;
            words_loaded_q <= words_loaded_d;
            cycle_count_q  <= cycle_count_d;
            ptr_q          <= ptr_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign load_ready_o   = (state_q == S_LOAD);
    assign state_o        = state_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign done_o         = done_q;
    assign timeout_o      = timeout_q;
    assign overflow_o     = overflow_q;
    assign words_loaded_o = words_loaded_q;
    assign cycle_count_o  = cycle_count_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl: a default-size instance for load/hold/run flows and
// a 3-bit-address instance for the image-overflow case; RAM writes checked via scoreboard.
module tb_cpu_boot_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        start_a, valid_a, last_a, halt_a;
    logic [15:0] data_a;
    logic        ready_a, we_a, cpu_rst_a, done_a, timeout_a, overflow_a;
    logic [7:0]  addr_a;
    logic [15:0] wdata_a;
    logic [2:0]  state_a;
    logic [8:0]  words_a;
    logic [31:0] cycles_a;

    logic        start_b, valid_b, last_b, halt_b;
    logic [15:0] data_b;
    logic        ready_b, we_b, cpu_rst_b, done_b, timeout_b, overflow_b;
    logic [2:0]  addr_b;
    logic [15:0] wdata_b;
    logic [2:0]  state_b;
    logic [3:0]  words_b;
    logic [7:0]  cycles_b;

    cpu_boot_ctrl #(.ADDR_W(8), .DATA_W(16), .RESET_HOLD(10), .RUN_LIMIT(100), .CNT_W(32)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .load_valid_i(valid_a),
        .load_ready_o(ready_a), .load_data_i(data_a), .load_last_i(last_a),
        .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_wdata_o(wdata_a),
        .cpu_rst_o(cpu_rst_a), .cpu_halt_i(halt_a), .state_o(state_a),
        .done_o(done_a), .timeout_o(timeout_a), .overflow_o(overflow_a),
        .words_loaded_o(words_a), .cycle_count_o(cycles_a)
    );

    cpu_boot_ctrl #(.ADDR_W(3), .DATA_W(16), .RESET_HOLD(3), .RUN_LIMIT(5), .CNT_W(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .load_valid_i(valid_b),
        .load_ready_o(ready_b), .load_data_i(data_b), .load_last_i(last_b),
        .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_wdata_o(wdata_b),
        .cpu_rst_o(cpu_rst_b), .cpu_halt_i(halt_b), .state_o(state_b),
        .done_o(done_b), .timeout_o(timeout_b), .overflow_o(overflow_b),
        .words_loaded_o(words_b), .cycle_count_o(cycles_b)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t        q_a[$];
    wr_t        q_b[$];
    logic       pend_a = 1'b0;
    logic       pend_b = 1'b0;
    logic [7:0] ptr_a = 8'd0;
    logic [7:0] ptr_b = 8'd0;
    int         n_assert = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample #1 after the edge and retire any expected RAM write
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        chk("mem_we_a", 64'(we_a), 64'(pend_a));
        if (pend_a && q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("mem_addr_a", 64'(addr_a), 64'(e.addr));
            chk("mem_wdata_a", 64'(wdata_a), 64'(e.data));
            $display("write A addr=%0d data=0x%04h", addr_a, wdata_a);
        end
        chk("mem_we_b", 64'(we_b), 64'(pend_b));
        if (pend_b && q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("mem_addr_b", 64'(addr_b), 64'(e.addr));
            chk("mem_wdata_b", 64'(wdata_b), 64'(e.data));
            $display("write B addr=%0d data=0x%04h", addr_b, wdata_b);
        end
        pend_a = 1'b0;
        pend_b = 1'b0;
    endtask

    task automatic send_a(input logic [15:0] d, input logic last);
        chk("load_ready_a", 64'(ready_a), 64'd1);
        q_a.push_back({ptr_a, d});
        ptr_a++;
        pend_a  = 1'b1;
        valid_a = 1'b1;
        data_a  = d;
        last_a  = last;
        tick();
        valid_a = 1'b0;
        last_a  = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d);
        chk("load_ready_b", 64'(ready_b), 64'd1);
        q_b.push_back({ptr_b, d});
        ptr_b++;
        pend_b  = 1'b1;
        valid_b = 1'b1;
        data_b  = d;
        last_b  = 1'b0;
        tick();
        valid_b = 1'b0;
    endtask

    task automatic start_load_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        ptr_a   = 8'd0;
        chk("state_load_a", 64'(state_a), 64'(S_LOAD));
    endtask

    task automatic wait_run_a();
        int n = 0;
        while (state_a !== S_RUN && n < 40) begin
            tick();
            n++;
        end
        chk("reach_run_a", 64'(state_a), 64'(S_RUN));
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_state"}, 64'(state_a), 64'(S_IDLE));
        chk({tag, "_cpu_rst"}, 64'(cpu_rst_a), 64'd1);
        chk({tag, "_ready"}, 64'(ready_a), 64'd0);
        chk({tag, "_we"}, 64'(we_a), 64'd0);
        chk({tag, "_addr"}, 64'(addr_a), 64'd0);
        chk({tag, "_wdata"}, 64'(wdata_a), 64'd0);
        chk({tag, "_flags"}, 64'({done_a, timeout_a, overflow_a}), 64'd0);
        chk({tag, "_words"}, 64'(words_a), 64'd0);
        chk({tag, "_cycles"}, 64'(cycles_a), 64'd0);
    endtask

    initial begin
        int hold_n;
        int run_n;
        rst = 1'b1;
        start_a = 0; valid_a = 0; last_a = 0; halt_a = 0; data_a = '0;
        start_b = 0; valid_b = 0; last_b = 0; halt_b = 0; data_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_a("por");
        rst = 1'b0;
        tick();
        chk("idle_a", 64'(state_a), 64'(S_IDLE));

        // Back-to-back image of four words
        start_load_a();
        for (int i = 0; i < 4; i++) begin
            send_a(16'(16'h1111 * (i + 1)), (i == 3));
            chk("words_b2b", 64'(words_a), 64'(i + 1));
        end
        chk("state_hold_a", 64'(state_a), 64'(S_HOLD));

        hold_n = 0;
        while (state_a === S_HOLD && hold_n < 30) begin
            chk("cpu_rst_hold", 64'(cpu_rst_a), 64'd1);
            hold_n++;
            tick();
        end
        chk("hold_cycles", 64'(hold_n), 64'd10);
        chk("run_state", 64'(state_a), 64'(S_RUN));
        chk("run_cpu_rst", 64'(cpu_rst_a), 64'd0);
        for (int k = 1; k < 7; k++) begin
            chk("run_count", 64'(cycles_a), 64'(k - 1));
            tick();
        end
        halt_a = 1'b1;
        tick();
        halt_a = 1'b0;
        $display("halt run: state=%0d done=%0d timeout=%0d cycles=%0d", state_a, done_a, timeout_a, cycles_a);
        chk("halt_state", 64'(state_a), 64'(S_DONE));
        chk("halt_done", 64'(done_a), 64'd1);
        chk("halt_timeout", 64'(timeout_a), 64'd0);
        chk("halt_cycles", 64'(cycles_a), 64'd7);
        chk("halt_cpu_rst", 64'(cpu_rst_a), 64'd1);
        tick();
        tick();
        chk("done_hold_cycles", 64'(cycles_a), 64'd7);
        chk("done_hold_flag", 64'(done_a), 64'd1);

        // Restart from DONE with a gapped loader stream; then run to timeout
        start_load_a();
        chk("restart_done_clr", 64'(done_a), 64'd0);
        chk("restart_words_clr", 64'(words_a), 64'd0);
        chk("restart_cycles_clr", 64'(cycles_a), 64'd0);
        for (int i = 0; i < 4; i++) begin
            send_a(16'(16'h1111 * (i + 1)), (i == 3));
            tick();
        end
        chk("gap_state", 64'(state_a), 64'(S_HOLD));
        chk("gap_words", 64'(words_a), 64'd4);
        wait_run_a();
        run_n = 0;
        while (state_a === S_RUN && run_n < 300) begin
            run_n++;
            tick();
        end
        $display("timeout run: cycles=%0d state=%0d timeout=%0d", cycles_a, state_a, timeout_a);
        chk("to_run_cycles", 64'(run_n), 64'd100);
        chk("to_state", 64'(state_a), 64'(S_DONE));
        chk("to_timeout", 64'(timeout_a), 64'd1);
        chk("to_done", 64'(done_a), 64'd0);
        chk("to_cycles", 64'(cycles_a), 64'd100);

        // Halt coinciding with the limit edge: halt takes priority
        start_load_a();
        chk("restart_timeout_clr", 64'(timeout_a), 64'd0);
        send_a(16'hBEEF, 1'b1);
        wait_run_a();
        repeat (99) tick();
        halt_a = 1'b1;
        tick();
        halt_a = 1'b0;
        $display("halt at limit: done=%0d timeout=%0d cycles=%0d", done_a, timeout_a, cycles_a);
        chk("tie_done", 64'(done_a), 64'd1);
        chk("tie_timeout", 64'(timeout_a), 64'd0);
        chk("tie_cycles", 64'(cycles_a), 64'd100);
        chk("tie_state", 64'(state_a), 64'(S_DONE));

        // Asynchronous reset in the middle of a load
        start_load_a();
        send_a(16'h5A5A, 1'b0);
        send_a(16'hA5A5, 1'b0);
        rst = 1'b1;
        #1;
        chk_reset_a("rst_load");
        tick();
        rst = 1'b0;
        tick();

        // Asynchronous reset in the middle of a run
        start_load_a();
        send_a(16'h0F0F, 1'b1);
        wait_run_a();
        repeat (3) tick();
        chk("pre_rst_cpu_rst", 64'(cpu_rst_a), 64'd0);
        rst = 1'b1;
        #1;
        chk_reset_a("rst_run");
        tick();
        rst = 1'b0;
        tick();

        // Small RAM: nine words without last; only eight fit
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        ptr_b = 8'd0;
        chk("b_state_load", 64'(state_b), 64'(S_LOAD));
        for (int i = 0; i < 8; i++) begin
            send_b(16'(16'hA000 + i));
        end
        $display("overflow: state=%0d overflow=%0d words=%0d", state_b, overflow_b, words_b);
        chk("ovf_state", 64'(state_b), 64'(S_HOLD));
        chk("ovf_flag", 64'(overflow_b), 64'd1);
        chk("ovf_words", 64'(words_b), 64'd8);
        valid_b = 1'b1;
        data_b  = 16'hA008;
        chk("ovf_ready_9th", 64'(ready_b), 64'd0);
        tick();
        valid_b = 1'b0;
        chk("ovf_words_after", 64'(words_b), 64'd8);
        chk("ovf_addr_after", 64'(addr_b), 64'd7);
        chk("ovf_state_after", 64'(state_b), 64'(S_HOLD));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_boot_ctrl.md
Name: cpu_boot_ctrl

Overview:
Synthesisable boot/run controller that sits between an external loader stream and the Cpu top. It streams an instruction image into the Cpu RAM write port while holding the Cpu in reset. It then holds reset for a programmable number of cycles, releases the Cpu, and supervises execution until halt or a cycle-limit timeout. It generalises the bench-only preload / reset / run-for-N sequence into parametrised hardware usable on silicon and in every test.

Parameters:
ADDR_W, 8, RAM address width; image depth is 2**ADDR_W words
DATA_W, 16, instruction/data word width
RESET_HOLD, 10, cycles cpu_rst stays asserted after load completes (must be >= 1)
RUN_LIMIT, 100, max RUN cycles before timeout; 0 = unlimited
CNT_W, 32, width of cycle_count

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin load sequence; sampled in IDLE and DONE only
load_valid  in  1  loader word valid
load_ready  out  1  controller accepts word (high only in LOAD)
load_data  in  DATA_W  instruction word
load_last  in  1  final word of image, qualified by load_valid
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM write address
mem_wdata  out  DATA_W  RAM write data
cpu_rst  out  1  reset to Cpu, active-high
cpu_halt  in  1  Cpu halt indication, sampled in RUN only
state  out  3  IDLE=0 LOAD=1 HOLD=2 RUN=3 DONE=4
done  out  1  sticky: Cpu halted
timeout  out  1  sticky: RUN_LIMIT reached without halt
overflow  out  1  sticky: image filled RAM without load_last
words_loaded  out  ADDR_W+1  words written this load
cycle_count  out  CNT_W  RUN cycles elapsed; frozen in DONE

Behaviour:
- Reset (async, immediate) values:
  - state=IDLE, cpu_rst=1, load_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - done=0, timeout=0, overflow=0, words_loaded=0, cycle_count=0.
  - Reset mid-load or mid-run drops mem_we at once; no partial write completes after rst.
- cpu_rst=1 in every state except RUN. All outputs are registered; load_ready is decoded from the state register.
- IDLE:
  - start=1 -> LOAD.
  - Clears done, timeout, overflow, words_loaded and cycle_count; internal address pointer set to 0.
- LOAD:
  - Handshake occurs on an edge where load_valid & load_ready.
  - Each handshake registers mem_we=1, mem_addr=pointer, mem_wdata=load_data for exactly the following cycle; pointer and words_loaded increment.
  - mem_we=0 on cycles with no handshake. Write latency is 1 cycle; back-to-back words sustain 1 word/cycle.
  - Handshake with load_last=1 -> HOLD.
  - Handshake at pointer=2**ADDR_W-1 with load_last=0 -> HOLD and overflow=1. The pointer never wraps.
- HOLD:
  - load_ready=0; loader inputs ignored.
  - Internal hold counter starts at 0; exits to RUN on the edge where it equals RESET_HOLD-1, so exactly RESET_HOLD HOLD cycles occur.
  - The final mem_we pulse lands in the first HOLD cycle.
- RUN:
  - cpu_rst=0; cycle_count increments on every RUN edge.
  - cpu_halt=1 sampled -> DONE with done=1.
  - RUN_LIMIT!=0 and cycle_count==RUN_LIMIT-1 on an edge -> DONE with timeout=1. cycle_count then equals RUN_LIMIT.
  - Halt and limit on the same edge: halt wins (done=1, timeout=0).
- DONE:
  - cpu_rst=1; flags and counters hold.
  - start=1 -> LOAD, clearing flags/counters as in IDLE.
- start is ignored in LOAD, HOLD and RUN.
- cycle_count saturates at all-ones when RUN_LIMIT=0.

Test Plan:
- Reset then start, stream 4 words 0x1111..0x4444 back-to-back with last on word 4 -> mem_we high 4 consecutive cycles, addr 0..3, words_loaded=4, state=HOLD after 4th handshake.
- Same image with load_valid toggling 1/0 -> mem_we pulses only after handshakes, addresses still contiguous 0..3, no duplicate writes.
- After load with RESET_HOLD=10 -> cpu_rst high exactly 10 cycles in HOLD, then 0; cpu_halt pulsed on 7th RUN cycle -> DONE, done=1, timeout=0, cycle_count=7, cpu_rst=1.
- No halt, RUN_LIMIT=100 -> DONE after exactly 100 RUN cycles, timeout=1, cycle_count=100. Repeat with halt asserted on cycle 100 -> done=1, timeout=0.
- ADDR_W=3, stream 9 words without last -> 8 writes (addr 0..7), overflow=1, state=HOLD; 9th word not accepted (load_ready=0).
- Assert rst during LOAD after 2 words and during RUN -> all outputs at reset values immediately. Restart start from DONE -> flags cleared, new load begins at addr 0.
